// File: rtl/siso_loopback_controller.sv
// siso_loopback_controller: serializes handshaked words onto a SISO chain and checks the looped-back result
// Ports:
//   clk, rst                 clock and synchronous active-high reset, shared with the chain
//   tx_valid, tx_data        producer word offer; tx_ready accepts it
//   sr_din, sr_q             registered serial bit to the chain, serial bit back from its last stage
//   rx_valid, rx_data, err   one-cycle completion pulse, reassembled word, mismatch flag
//   busy                     a frame is in flight
//   frame_cnt, err_cnt       saturating completed-frame and errored-frame counters
module siso_loopback_controller #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  output logic             sr_din,
  input  logic             sr_q,
  output logic             rx_valid,
  output logic [WIDTH-1:0] rx_data,
  output logic             err,
  output logic             busy,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      err_cnt
);
  localparam int CW = $clog2(WIDTH + DEPTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH + DEPTH - 1);
  localparam logic [CW-1:0] RX0 = CW'(DEPTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_c;
  logic [WIDTH-1:0] r_tx_buf, r_cmp, r_rx_shift, r_rx_data;
  logic [WIDTH-1:0] w_tx_src, w_tx_rest, w_rx_next;
  logic [15:0] r_frame_cnt, r_err_cnt;
  logic r_sr_din, r_rx_valid, r_err;
  logic w_tx_ready, w_busy, w_accept, w_last, w_rx_en, w_tx_bit, w_err;
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_tx_ready = r_state == IDLE;
    w_busy = r_state == RUN;
    w_accept = w_tx_ready && tx_valid;
    w_last = w_busy && r_c == LAST;
    w_next = w_accept ? RUN : w_last ? IDLE : r_state;
  end
  // tx_buf holds the not-yet-sent bits; it shifts zeros in, so sr_din drains zeros once data runs out
  assign w_tx_src = w_accept ? tx_data : r_tx_buf;
  assign w_tx_bit = MSB_FIRST ? w_tx_src[WIDTH-1] : w_tx_src[0];
  assign w_tx_rest = MSB_FIRST ? w_tx_src << 1 : w_tx_src >> 1;
  // first received bit ends at bit 0 (LSB first) or bit WIDTH-1 (MSB first) after WIDTH shifts
  assign w_rx_next = MSB_FIRST ? {r_rx_shift[WIDTH-2:0], sr_q} : {sr_q, r_rx_shift[WIDTH-1:1]};
  assign w_rx_en = w_busy && r_c >= RX0;
  assign w_err = w_rx_next != r_cmp;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c <= '0;
      r_tx_buf <= '0;
      r_cmp <= '0;
      r_rx_shift <= '0;
      r_sr_din <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data <= '0;
      r_err <= 1'b0;
      r_frame_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      r_rx_valid <= w_last;
      r_c <= w_accept ? '0 : w_busy ? r_c + CW'(1) : r_c;
      r_sr_din <= (w_accept || w_busy) && w_tx_bit;
      if (w_accept || w_busy) r_tx_buf <= w_tx_rest;
      if (w_accept) r_cmp <= tx_data;
      if (w_accept) r_rx_shift <= '0;
      if (w_rx_en) r_rx_shift <= w_rx_next;
      if (w_last) begin
        r_rx_data <= w_rx_next;
        r_err <= w_err;
        if (r_frame_cnt != '1) r_frame_cnt <= r_frame_cnt + 16'd1;
        if (w_err && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end
  assign tx_ready = w_tx_ready;
  assign busy = w_busy;
  assign sr_din = r_sr_din;
  assign rx_valid = r_rx_valid;
  assign rx_data = r_rx_data;
  assign err = r_err;
  assign frame_cnt = r_frame_cnt;
  assign err_cnt = r_err_cnt;
endmodule

// File: tb/tb_siso_loopback_controller.sv
// tb_siso_loopback_controller: directed bench for LSB-first and MSB-first controllers, each driving a 4-stage chain
module tb_siso_loopback_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_valid = 1'b1, tx_valid1 = 1'b0;
  logic [7:0] tx_data = 8'hA5, tx_data1 = 8'h00;
  logic tx_ready, sr_din, sr_q, rx_valid, err, busy;
  logic tx_ready1, sr_din1, sr_q1, rx_valid1, err1, busy1;
  logic [7:0] rx_data, rx_data1;
  logic [15:0] frame_cnt, err_cnt, frame_cnt1, err_cnt1;
  logic [3:0] ch0, ch1;
  logic force_zero = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    ch0 <= rst ? 4'd0 : {ch0[2:0], sr_din};
    ch1 <= rst ? 4'd0 : {ch1[2:0], sr_din1};
  end
  assign sr_q = force_zero ? 1'b0 : ch0[3];
  assign sr_q1 = ch1[3];

  siso_loopback_controller #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .sr_din(sr_din), .sr_q(sr_q), .rx_valid(rx_valid), .rx_data(rx_data), .err(err),
    .busy(busy), .frame_cnt(frame_cnt), .err_cnt(err_cnt));

  siso_loopback_controller #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid1), .tx_data(tx_data1), .tx_ready(tx_ready1),
    .sr_din(sr_din1), .sr_q(sr_q1), .rx_valid(rx_valid1), .rx_data(rx_data1), .err(err1),
    .busy(busy1), .frame_cnt(frame_cnt1), .err_cnt(err_cnt1));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_sr_din", sr_din, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_err", err, 0);
  endtask

  // Called at a negedge with the selected controller idle; offers d, then follows the frame to completion.
  task automatic frame(input bit msb, input logic [7:0] d, input logic [7:0] exp_rx, input logic exp_err,
                       input logic [15:0] exp_fc, input logic [15:0] exp_ec);
    if (msb) begin tx_valid1 = 1'b1; tx_data1 = d; end
    else begin tx_valid = 1'b1; tx_data = d; end
    @(negedge clk);
    tx_valid = 1'b0;
    tx_valid1 = 1'b0;
    for (int j = 0; j < 12; j++) begin
      chk("frame_sr_din", msb ? sr_din1 : sr_din, (j < 8) ? d[msb ? 7 - j : j] : 1'b0);
      chk("frame_busy", msb ? busy1 : busy, 1);
      chk("frame_tx_ready", msb ? tx_ready1 : tx_ready, 0);
      chk("frame_rx_valid_early", msb ? rx_valid1 : rx_valid, 0);
      @(negedge clk);
    end
    chk("done_rx_valid", msb ? rx_valid1 : rx_valid, 1);
    chk("done_rx_data", msb ? rx_data1 : rx_data, exp_rx);
    chk("done_err", msb ? err1 : err, exp_err);
    chk("done_tx_ready", msb ? tx_ready1 : tx_ready, 1);
    chk("done_busy", msb ? busy1 : busy, 0);
    chk("done_frame_cnt", msb ? frame_cnt1 : frame_cnt, exp_fc);
    chk("done_err_cnt", msb ? err_cnt1 : err_cnt, exp_ec);
    @(negedge clk);
    chk("after_rx_valid", msb ? rx_valid1 : rx_valid, 0);
    chk("after_rx_data_hold", msb ? rx_data1 : rx_data, exp_rx);
    chk("after_err_hold", msb ? err1 : err, exp_err);
  endtask

  initial begin
    // reset held two edges with tx_valid high: nothing may be accepted
    @(negedge clk);
    chk_reset();
    @(negedge clk);
    chk_reset();
    rst = 1'b0;
    // first accept lands on the first edge with rst low
    frame(1'b0, 8'hA5, 8'hA5, 1'b0, 16'd1, 16'd0);

    // back-to-back: accepts at k=0 and k=13 (tx_valid sampled high with tx_ready high)
    tx_valid = 1'b1;
    tx_data = 8'h3C;
    for (int k = 0; k < 27; k++) begin
      if (k == 1) tx_data = 8'hC3;
      if (k == 14) tx_valid = 1'b0;
      if (k == 13) begin
        chk("b2b_ready_13", tx_ready, 1);
        chk("b2b_rx_valid_1", rx_valid, 1);
        chk("b2b_rx_data_1", rx_data, 16'h3C);
        chk("b2b_err_1", err, 0);
        chk("b2b_frame_cnt_1", frame_cnt, 2);
      end else if (k == 26) begin
        chk("b2b_rx_valid_2", rx_valid, 1);
        chk("b2b_rx_data_2", rx_data, 16'hC3);
        chk("b2b_err_2", err, 0);
        chk("b2b_frame_cnt_2", frame_cnt, 3);
      end else begin
        chk("b2b_ready", tx_ready, (k == 0) ? 16'd1 : 16'd0);
        chk("b2b_rx_valid_idle", rx_valid, 0);
      end
      @(negedge clk);
    end

    // fresh counts, then a 0xFF frame with the chain output stuck low
    rst = 1'b1;
    @(negedge clk);
    chk_reset();
    rst = 1'b0;
    force_zero = 1'b1;
    frame(1'b0, 8'hFF, 8'h00, 1'b1, 16'd1, 16'd1);
    force_zero = 1'b0;

    // MSB-first controller
    frame(1'b1, 8'h81, 8'h81, 1'b0, 16'd1, 16'd0);
    frame(1'b1, 8'h1E, 8'h1E, 1'b0, 16'd2, 16'd0);

    // reset during cycle c=5 of a frame
    tx_valid = 1'b1;
    tx_data = 8'hFF;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset();
    rst = 1'b0;
    for (int k = 0; k < 13; k++) begin
      chk("mid_no_rx_valid", rx_valid, 0);
      chk("mid_idle_sr_din", sr_din, 0);
      @(negedge clk);
    end
    frame(1'b0, 8'h5A, 8'h5A, 1'b0, 16'd1, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
